// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//
// Registered, handshaked ALU execution stage. It consumes the 3-bit ALUControl
// code from the ALU decoder and returns a registered result and zero flag.
// ADD/SUB/AND/OR/SLT complete in one cycle. An optional iterative shifter
// (SLL/SRL/SRA) takes one cycle per bit of shift amount.
//
// Build option:
//   ALU_SHIFT_EN  - when defined, codes 100/110/111 perform SLL/SRL/SRA through
//                   the SHIFT state. When undefined, those codes execute as ADD
//                   and the FSM is IDLE/DONE only.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   request valid
//   in_ready    out  request can be accepted this cycle
//   ALUControl  in   [2:0] operation code
//   SrcA        in   [WIDTH-1:0] operand A
//   SrcB        in   [WIDTH-1:0] operand B (shift amount in low log2(WIDTH) bits)
//   out_valid   out  result valid
//   out_ready   in   consumer accepts the result
//   ALUResult   out  [WIDTH-1:0] registered result
//   Zero        out  registered, 1 when ALUResult is zero

module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    // Elaboration-time parameter sanity check.
    if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("alu_exec_unit: WIDTH must be a power of two and at least 8");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifdef ALU_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam int unsigned SHW     = $clog2(WIDTH);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             retire;
    logic             slt;
    logic [WIDTH-1:0] alu_out;

`ifdef ALU_SHIFT_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    // Low two bits of the shift code: 00 SLL, 10 SRL, 11 SRA.
    logic [1:0]       shop_q, shop_d;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] shift_step;
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // in_ready follows out_ready in DONE so a retire and a new accept can
    // share a cycle; this is the only combinational input-to-output path.
    always_comb begin
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = (state_q == ST_DONE);
    end

    assign accept    = in_valid && in_ready;
    assign retire    = out_valid && out_ready;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

    // ------------------------------------------------------------------
    // One-cycle datapath, evaluated on the incoming operands
    // ------------------------------------------------------------------
    assign slt = $signed(SrcA) < $signed(SrcB);

    always_comb begin
        case (ALUControl)
            3'b001:  alu_out = SrcA - SrcB;
            3'b010:  alu_out = SrcA & SrcB;
            3'b011:  alu_out = SrcA | SrcB;
            3'b101:  alu_out = {{(WIDTH - 1){1'b0}}, slt};
`ifdef ALU_SHIFT_EN
            // Shifts preload the working register with A; a shift by zero
            // therefore completes directly with A as the result.
            3'b100, 3'b110, 3'b111: alu_out = SrcA;
`endif
            // ADD and every unused code.
            default: alu_out = SrcA + SrcB;
        endcase
    end

`ifdef ALU_SHIFT_EN
    // ------------------------------------------------------------------
    // Iterative shifter: one bit position per cycle
    // ------------------------------------------------------------------
    assign is_shift = ALUControl[2] && (ALUControl[1:0] != 2'b01);
    assign shamt    = SrcB[SHW-1:0];

    always_comb begin
        case (shop_q)
            2'b10:   shift_step = {1'b0, result_q[WIDTH-1:1]};
            2'b11:   shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default: shift_step = {result_q[WIDTH-2:0], 1'b0};
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ALU_SHIFT_EN
        cnt_d    = cnt_q;
        shop_d   = shop_q;
`endif

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
`ifdef ALU_SHIFT_EN
            ST_SHIFT: begin
                result_d = shift_step;
                zero_d   = (shift_step == '0);
                cnt_d    = cnt_q - 1'b1;
                // A count of 1 means this cycle performs the final shift.
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (retire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is only possible from IDLE or from DONE while retiring, so
        // a new load overrides whatever the state decode chose above.
        if (accept) begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = ST_DONE;
`ifdef ALU_SHIFT_EN
            if (is_shift && (shamt != '0)) begin
                state_d = ST_SHIFT;
                cnt_d   = shamt;
                shop_d  = ALUControl[1:0];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ALU_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            shop_q <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            shop_q <= shop_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//
// Self-checking bench for alu_exec_unit (WIDTH = 32). A directed vector table,
// hand-written backpressure / streaming / reset sequences and a randomized
// phase are checked against a behavioural model built from plain arithmetic.

module tb_alu_exec_unit;

    localparam int W  = 32;
    localparam int SW = $clog2(W);

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;

    int n_cmp;
    int n_bad;

    alu_exec_unit #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUControl(ALUControl),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALUResult (ALUResult),
        .Zero      (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         zero;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic is_shift_code(input logic [2:0] code);
`ifdef ALU_SHIFT_EN
        return (code == 3'd4) || (code == 3'd6) || (code == 3'd7);
`else
        return (code == 3'd8 - 3'd8) && 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [2:0] code,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [W-1:0] sa;
        int s;
        sa = a;
        s  = int'(b[SW-1:0]);
        if (is_shift_code(code)) begin
            if (code == 3'd4) return a << s;
            if (code == 3'd6) return a >> s;
            return sa >>> s;
        end
        case (code)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return a + b;
        endcase
    endfunction

    // Edges from the accepting edge (inclusive) until out_valid is first seen.
    function automatic int ref_latency(input logic [2:0] code, input logic [W-1:0] b);
        int s;
        s = int'(b[SW-1:0]);
        return is_shift_code(code) ? 1 + s : 1;
    endfunction

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input logic zero, input int lat);
        vec_t v;
        v.code = code;
        v.a    = a;
        v.b    = b;
        v.res  = res;
        v.zero = zero;
        v.lat  = lat;
        vecs.push_back(v);
    endtask

    // Present a request and return at #1 after the accepting edge.
    task automatic issue(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        int waited;
        waited     = 0;
        ALUControl = code;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: in_ready got 0, required 1");
        end
        @(posedge clk);
        #1;
        // Scramble operands after accept; the unit must use the captured copy.
        in_valid   = 1'b0;
        ALUControl = 3'($urandom_range(0, 7));
        SrcA       = $urandom;
        SrcB       = $urandom;
    endtask

    task automatic wait_result(output logic [W-1:0] res, output logic z, output int lat);
        lat = 1;
        while (!out_valid && lat < 2 * W + 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: out_valid got 0, required 1");
        end
        res = ALUResult;
        z   = Zero;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] got;
        logic         gz;
        int           lat;
        logic [2:0]   one_cycle_codes [5];
        logic [2:0]   sc [8];
        logic [W-1:0] sa [8];
        logic [W-1:0] sb [8];
        logic         stale;

        n_cmp      = 0;
        n_bad      = 0;
        in_valid   = 1'b0;
        ALUControl = 3'd0;
        SrcA       = '0;
        SrcB       = '0;
        out_ready  = 1'b0;
        rst_n      = 1'b0;
        one_cycle_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(ALUResult), 64'd0);
        check("reset_zero", 64'(Zero), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        // Directed vector table
        add_vec(3'd0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1);
        add_vec(3'd1, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1);
        add_vec(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
        add_vec(3'd5, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
        add_vec(3'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
        add_vec(3'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1);
        add_vec(3'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
        add_vec(3'd3, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1'b0, 1);
        add_vec(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
        add_vec(3'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
`ifdef ALU_SHIFT_EN
        add_vec(3'd7, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 5);
        add_vec(3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1);
        add_vec(3'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32);
        add_vec(3'd4, 32'h0000_0002, 32'h0000_0003, 32'h0000_0010, 1'b0, 4);
        add_vec(3'd4, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 2);
        add_vec(3'd6, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 3);
`else
        add_vec(3'd4, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b0, 1);
        add_vec(3'd6, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1);
        add_vec(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1);
`endif

        out_ready = 1'b1;
        foreach (vecs[i]) begin
            issue(vecs[i].code, vecs[i].a, vecs[i].b);
            wait_result(got, gz, lat);
            check($sformatf("vec%0d_result", i), 64'(got), 64'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), 64'(gz), 64'(vecs[i].zero));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end
        @(posedge clk);
        #1;
        check("drain_to_idle", 64'(out_valid), 64'd0);

        // Backpressure: AND result held for 3 cycles, then retire + accept OR
        out_ready = 1'b0;
        issue(3'd2, 32'h0000_F0F0, 32'h0000_FF00);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_result", k), 64'(ALUResult), 64'h0000_F000);
            check($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 3'd3;
        SrcA       = 32'h0000_F0F0;
        SrcB       = 32'h0000_0F0F;
        #1;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b_out_valid", 64'(out_valid), 64'd1);
        check("b2b_result", 64'(ALUResult), 64'h0000_FFFF);

        // Streaming: 8 one-cycle ops with in_valid and out_ready held high
        for (int i = 0; i < 8; i++) begin
            sc[i] = one_cycle_codes[$urandom_range(0, 4)];
            sa[i] = $urandom;
            sb[i] = (i == 3) ? sa[i] : $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            ALUControl = sc[i];
            SrcA       = sa[i];
            SrcB       = sb[i];
            @(posedge clk);
            #1;
            check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d_result", i), 64'(ALUResult),
                  64'(ref_result(sc[i], sa[i], sb[i])));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("stream_drain", 64'(out_valid), 64'd0);

        // Randomized transactions against the model
        for (int t = 0; t < 150; t++) begin
            logic [2:0]   c;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] e;
            int           stall;
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
            e = ref_result(c, a, b);
            out_ready = 1'b1;
            issue(c, a, b);
            out_ready = 1'($urandom_range(0, 1));
            wait_result(got, gz, lat);
            check($sformatf("rnd%0d_result", t), 64'(got), 64'(e));
            check($sformatf("rnd%0d_zero", t), 64'(gz), 64'(e == '0));
            check($sformatf("rnd%0d_latency", t), 64'(lat), 64'(ref_latency(c, b)));
            stall = $urandom_range(0, 2);
            out_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d_hold", t), 64'({out_valid, ALUResult}), 64'({1'b1, e}));
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;

        // Reset while a result waits in DONE
        out_ready = 1'b0;
        issue(3'd0, 32'h0000_0007, 32'h0000_0009);
        check("done_before_reset", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", 64'(out_valid), 64'd0);
        check("rst_done_result", 64'(ALUResult), 64'd0);
        check("rst_done_zero", 64'(Zero), 64'd0);
        check("rst_done_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_done_no_stale", 64'(out_valid), 64'd0);

`ifdef ALU_SHIFT_EN
        // Reset in the middle of a 20-bit shift
        out_ready = 1'b1;
        issue(3'd4, 32'h0000_0001, 32'd20);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("mid_shift_busy", 64'({out_valid, in_ready}), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_shift_out_valid", 64'(out_valid), 64'd0);
        check("rst_shift_result", 64'(ALUResult), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_shift_in_ready", 64'(in_ready), 64'd1);
        stale = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) stale = 1'b1;
        end
        check("rst_shift_no_stale", 64'(stale), 64'd0);
`endif

        // Recovery after reset
        out_ready = 1'b1;
        issue(3'd1, 32'h0000_0010, 32'h0000_0001);
        wait_result(got, gz, lat);
        check("recover_result", 64'(got), 64'h0000_000F);
        check("recover_latency", 64'(lat), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered, handshaked ALU execution stage that consumes the 3-bit `ALUControl` code produced by the control unit's ALU decoder and returns the result and zero flag. It sits between operand fetch and writeback/branch logic in the single-cycle core's planned multi-cycle variant. It performs ADD/SUB/AND/OR/SLT in one cycle. An optional iterative shifter takes one cycle per shift bit.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a power of two and ≥ 8.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `in_valid`, input, 1: operation request valid.
- `in_ready`, output, 1: unit can accept a request this cycle.
- `ALUControl`, input, 3: operation code. 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT. Shift codes 100 SLL, 110 SRL, 111 SRA (macro only).
- `SrcA`, input, WIDTH: operand A.
- `SrcB`, input, WIDTH: operand B. For shifts, the shift amount is `SrcB[log2(WIDTH)-1:0]`.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `ALUResult`, output, WIDTH: registered result.
- `Zero`, output, 1: registered, equals 1 exactly when ALUResult is 0.

## Operation
- **Handshake**
  - A request is accepted when `in_valid && in_ready`. Operands and code are captured on that edge.
  - A result is retired when `out_valid && out_ready`.
- **FSM**
  - **IDLE**: `in_ready`=1, `out_valid`=0. On accept of a one-cycle op, go to DONE. On accept of a shift with amount > 0, go to SHIFT. On accept of a shift with amount = 0, go to DONE with result = SrcA.
  - **SHIFT**: `in_ready`=0, `out_valid`=0.
    - Each cycle: shift the working register by 1 (SLL fills 0; SRL fills 0; SRA fills the sign bit), then decrement the counter.
    - When the counter reaches 1, this cycle's shift is the last one; go to DONE.
  - **DONE**: `out_valid`=1.
    - `in_ready` = `out_ready`, so back-to-back accept is allowed in the same cycle as retire.
    - On retire with a new accept: load the new op (to DONE or SHIFT as above).
    - On retire without a new accept: go to IDLE.
    - Without retire: hold.
- **Arithmetic**
  - ADD/SUB are modulo 2^WIDTH; overflow is ignored.
  - SLT is a signed two's-complement compare. Result = {WIDTH-1 zeros, A<B}.
  - AND/OR are bitwise.
- **Unknown codes**: unused codes execute as ADD in one cycle. This matches the decoder's invalid-case default.
- **Output stability**: `ALUResult` and `Zero` stay stable while `out_valid`=1 and `out_ready`=0.

## Timing
- **Reset values**: state IDLE, `in_ready`=1, `out_valid`=0, `ALUResult`=0, `Zero`=0, counter 0.
- **Reset during operation**: reset asserted mid-SHIFT or in DONE aborts the operation. The result is discarded; there is no partial output.
- **Latency**
  - One-cycle op accepted at edge N: `out_valid`=1 after edge N+1.
  - Shift with amount s > 0 accepted at edge N: `out_valid` after edge N+1+s.
  - Shift amount WIDTH-1 gives the maximum latency of WIDTH cycles.
- **Throughput**: one one-cycle op per clock when `out_ready` is held high.
- **Combinational paths**: `in_ready` depends combinationally on `out_ready` in DONE only. No other combinational input-to-output path exists.
- **Ignored inputs**: `in_valid` is ignored during SHIFT, and `in_valid` is not required to stay asserted after accept.

## Configuration
- `ALU_SHIFT_EN` defined:
  - Codes 100/110/111 perform SLL/SRL/SRA iteratively via the SHIFT state, using a log2(WIDTH)-bit counter.
- `ALU_SHIFT_EN` undefined:
  - The SHIFT state, counter and shift datapath are absent.
  - Codes 100/110/111 execute as one-cycle ADD.
  - FSM is IDLE/DONE only.

## Test plan
- **Reset then ADD.** Release reset. Issue ADD A=0x00000005, B=0x00000003 with out_ready=1. Expect in_ready=1 at reset, out_valid one cycle after accept, ALUResult=0x00000008, Zero=0.
- **SUB to zero and SLT sign.**
  - SUB A=B=0x1234 gives result 0, Zero=1.
  - SLT A=0xFFFFFFFF, B=0x00000001 gives result 1.
  - SLT A=1, B=0xFFFFFFFF gives result 0.
- **Backpressure and back-to-back.**
  - Hold out_ready=0 for 3 cycles after an AND 0xF0F0/0xFF00 result. Expect 0x0000F000 stable and in_ready=0.
  - Then raise out_ready with in_valid carrying OR 0xF0F0/0x0F0F. Expect retire plus accept in the same cycle and next result 0x0000FFFF.
- **Streaming.** Hold in_valid=1 and out_ready=1 for 8 consecutive ADDs. Expect 8 results on 8 consecutive cycles, in order.
- **Shifts (`ALU_SHIFT_EN`).**
  - SRA A=0x80000000, B=4 gives 0xF8000000 exactly 5 cycles after accept.
  - SLL by 0 gives A after 1 cycle.
  - SRL A=0x80000000, B=31 gives 0x00000001 after 32 cycles.
  - Without the macro, code 100 with A=2, B=3 gives 5 after 1 cycle.
- **Reset mid-shift.** Assert rst_n=0 during a 20-cycle SLL. Expect immediate out_valid=0, ALUResult=0, in_ready=1 after release, and no stale result.
